mul_unit_iter: RTL and testbench

//  Iterative radix-2 multiplier for RV32M MUL/MULH/MULHSU/MULHU in the EX stage.

---
 rtl/mul_unit_iter_pkg.sv | 13 +
 rtl/mul_unit_iter_if.sv | 25 ++
 rtl/mul_unit_iter_sign_fix.sv | 45 ++++
 rtl/mul_unit_iter.sv | 110 +++++++++++
 tb/tb_mul_unit_iter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_unit_iter_pkg.sv
// Shared definitions for the iterative RV32M multiplier: op encodings and FSM state codes.
package mul_unit_iter_pkg;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_unit_iter_if.sv
// start_mul/done_mul handshake bundle between the EX-stage multiplier and its requester.
interface mul_unit_iter_if #(parameter int XLEN = 32);

   logic            start_mul;
   logic [1:0]      op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            done_mul;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output start_mul, op, src_a, src_b, rd_in, flush,
      input  busy, done_mul, result, rd_out
   );

   modport slave (
      input  start_mul, op, src_a, src_b, rd_in, flush,
      output busy, done_mul, result, rd_out
   );

endinterface

// File: rtl/mul_unit_iter_sign_fix.sv
// Combinational sign handling: operand magnitudes and neg flag at accept,
// final two's-complement negate and word select at completion.
module mul_sign_fix
   import mul_unit_iter_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]        op,
   input  logic [XLEN-1:0]   src_a,
   input  logic [XLEN-1:0]   src_b,
   output logic [XLEN-1:0]   mag_a,
   output logic [XLEN-1:0]   mag_b,
   output logic              neg,
   input  logic [1:0]        res_op,
   input  logic              res_neg,
   input  logic [2*XLEN-1:0] acc,
   output logic [XLEN-1:0]   result
);

   // The most negative value negates onto itself, which read unsigned is exactly 2^(XLEN-1).
   function automatic logic [XLEN-1:0] abs_w(input logic signed [XLEN-1:0] v, input logic s);
      logic signed [XLEN-1:0] n;
      n = -v;
      return s ? n : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v, input logic s);
      return s ? (~v + 1'b1) : v;
   endfunction

   logic            sa;
   logic            sb;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      sa     = src_a[XLEN-1] & ((op == MUL_OP_MULH) | (op == MUL_OP_MULHSU));
      sb     = src_b[XLEN-1] & (op == MUL_OP_MULH);
      mag_a  = abs_w(src_a, sa);
      mag_b  = abs_w(src_b, sb);
      neg    = sa ^ sb;
      prod   = neg_p(acc, res_neg);
      result = (res_op == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

endmodule

// File: rtl/mul_unit_iter.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional build macro: MUL_EARLY_OUT_EN ends RUN once the multiplier is exhausted.
module mul_unit_iter
   import mul_unit_iter_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic        clk,
   input logic        rst,
   mul_unit_iter_if.slave bus
);

   localparam int CNT_W = $clog2(XLEN);

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   mplier_next;
   logic [1:0]        op_q;
   logic              neg_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              neg;
   logic [XLEN-1:0]   fixed_result;
   logic              accept;
   logic              last;

   mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .op      (bus.op),
      .src_a   (bus.src_a),
      .src_b   (bus.src_b),
      .mag_a   (mag_a),
      .mag_b   (mag_b),
      .neg     (neg),
      .res_op  (op_q),
      .res_neg (neg_q),
      .acc     (acc_next),
      .result  (fixed_result)
   );

   always_comb begin
      accept      = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start_mul && !bus.flush;
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mplier_next = mplier >> 1;
      last        = (cnt == CNT_W'(XLEN - 1));
`ifdef MUL_EARLY_OUT_EN
      last        = last || (mplier_next == '0);
`endif
      state_next  = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_RUN;
         ST_RUN: begin
            if (bus.flush)  state_next = ST_IDLE;
            else if (last)  state_next = ST_DONE;
         end
         ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Control and architecturally visible outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state <= state_next;
         if (accept)
            cnt <= '0;
         else if (state == ST_RUN)
            cnt <= cnt + CNT_W'(1);
         // A flushed final iteration must leave the previous result visible.
         if ((state == ST_RUN) && last && !bus.flush) begin
            result_q <= fixed_result;
            rd_out_q <= rd_q;
         end
      end
   end

   // Shift-add datapath, loaded on accept and advanced once per RUN cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= bus.op;
         rd_q   <= bus.rd_in;
         neg_q  <= neg;
         acc    <= '0;
         mcand  <= {{XLEN{1'b0}}, mag_a};
         mplier <= mag_b;
      end else if (state == ST_RUN) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier_next;
      end
   end

   assign bus.busy     = (state == ST_RUN);
   assign bus.done_mul = (state == ST_DONE) && !bus.flush;
   assign bus.result   = result_q;
   assign bus.rd_out   = rd_out_q;

endmodule

// File: tb/tb_mul_unit_iter.sv
// Scoreboard bench for mul_unit_iter: directed RV32M cases, handshake corners and a random sweep.
module tb_mul_unit_iter;
   import mul_unit_iter_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mul_unit_iter_if #(.XLEN(XLEN)) bus();
   mul_unit_iter #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int passed = 0;
   int total  = 0;
   logic [31:0] last_res;
   logic [4:0]  last_rd;

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
      logic [31:0] m;
      int n;
      m = ((op == MUL_OP_MULH) && b[31]) ? (~b + 32'd1) : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifdef MUL_EARLY_OUT_EN
      return 1 + n;
`else
      return (n > 0) ? XLEN + 1 : 0;
`endif
   endfunction

   task automatic push_exp(input logic [31:0] res, input logic [4:0] rd);
      exp_t e;
      e.res = res;
      e.rd  = rd;
      sb.push_back(e);
   endtask

   function automatic exp_t pop_exp();
      exp_t e;
      e.res = 'x;
      e.rd  = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      return e;
   endfunction

   // Called at a negedge: issues one request and waits (bounded) for done_mul.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int busy_n, output bit seen);
      bus.op = op; bus.src_a = a; bus.src_b = b; bus.rd_in = rd; bus.start_mul = 1'b1;
      lat = 0; busy_n = 0; seen = 1'b0;
      while (lat < 100 && !seen) begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.start_mul = 1'b0;
         if (bus.busy) busy_n++;
         if (bus.done_mul) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start_mul = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
      bus.src_a = '0; bus.src_b = '0; bus.rd_in = '0;
      repeat (3) @(negedge clk);
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
      total++; if (bus.done_mul !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done_mul); else passed++;
      total++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus.result); else passed++;
      total++; if (bus.rd_out !== 5'h0) $display("FAIL reset_rd: got %h want 0", bus.rd_out); else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mul_basic();
      int lat, bn; bit seen; exp_t e;
      push_exp(32'd42, 5'd3);
      run_op(MUL_OP_MUL, 32'd7, 32'd6, 5'd3, lat, bn, seen);
      e = pop_exp();
      total++; if (!seen || lat != exp_lat(MUL_OP_MUL, 32'd6)) $display("FAIL basic_latency: got %0d (seen %0d) want %0d", lat, seen, exp_lat(MUL_OP_MUL, 32'd6)); else passed++;
      total++; if (bn != exp_lat(MUL_OP_MUL, 32'd6) - 1) $display("FAIL basic_busy_cycles: got %0d want %0d", bn, exp_lat(MUL_OP_MUL, 32'd6) - 1); else passed++;
      total++; if (bus.result !== e.res) $display("FAIL basic_result: got %h want %h", bus.result, e.res); else passed++;
      total++; if (bus.rd_out !== e.rd) $display("FAIL basic_rd: got %h want %h", bus.rd_out, e.rd); else passed++;
      @(negedge clk);
      total++; if (bus.done_mul !== 1'b0) $display("FAIL basic_done_pulse_width: got %b want 0", bus.done_mul); else passed++;
      total++; if (bus.result !== e.res) $display("FAIL basic_result_hold: got %h want %h", bus.result, e.res); else passed++;
   endtask

   task automatic test_signed_cases();
      logic [1:0]  ops [7] = '{MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU, MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MUL, MUL_OP_MULHSU};
      logic [31:0] as  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
      logic [31:0] bs  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] xs  [7] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000000, 32'h80000000, 32'h80000000};
      int lat, bn; bit seen; exp_t e;
      for (int i = 0; i < 7; i++) begin
         push_exp(xs[i], 5'(i + 8));
         run_op(ops[i], as[i], bs[i], 5'(i + 8), lat, bn, seen);
         e = pop_exp();
         total++; if (!seen || bus.result !== e.res) $display("FAIL signed_case%0d_result: got %h (seen %0d) want %h", i, bus.result, seen, e.res); else passed++;
         total++; if (bus.rd_out !== e.rd) $display("FAIL signed_case%0d_rd: got %h want %h", i, bus.rd_out, e.rd); else passed++;
         total++; if (lat != exp_lat(ops[i], bs[i])) $display("FAIL signed_case%0d_latency: got %0d want %0d", i, lat, exp_lat(ops[i], bs[i])); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int lat; bit seen, extra; exp_t e;
      push_exp(ref_mul(MUL_OP_MUL, 32'd9, 32'h40000009), 5'd4);
      bus.op = MUL_OP_MUL; bus.src_a = 32'd9; bus.src_b = 32'h40000009; bus.rd_in = 5'd4; bus.start_mul = 1'b1;
      lat = 0; seen = 1'b0;
      while (lat < 100 && !seen) begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.start_mul = 1'b0;
         if (lat == 5) begin bus.start_mul = 1'b1; bus.src_a = 32'd2; bus.src_b = 32'd2; bus.rd_in = 5'd9; end
         if (lat == 8) bus.start_mul = 1'b0;
         if (bus.done_mul) seen = 1'b1;
      end
      e = pop_exp();
      total++; if (!seen || lat != exp_lat(MUL_OP_MUL, 32'h40000009)) $display("FAIL ignore_start_latency: got %0d (seen %0d) want %0d", lat, seen, exp_lat(MUL_OP_MUL, 32'h40000009)); else passed++;
      total++; if (bus.result !== e.res) $display("FAIL ignore_start_result: got %h want %h", bus.result, e.res); else passed++;
      total++; if (bus.rd_out !== e.rd) $display("FAIL ignore_start_rd: got %h want %h", bus.rd_out, e.rd); else passed++;
      extra = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done_mul) extra = 1'b1; end
      total++; if (extra !== 1'b0) $display("FAIL ignore_start_no_restart: got done %b want 0", extra); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, bn; bit seen; exp_t e;
      push_exp(32'd33, 5'd1);
      run_op(MUL_OP_MUL, 32'd11, 32'd3, 5'd1, lat, bn, seen);
      e = pop_exp();
      total++; if (!seen || bus.result !== e.res) $display("FAIL b2b_first_result: got %h (seen %0d) want %h", bus.result, seen, e.res); else passed++;
      push_exp(32'd10000, 5'd2);
      run_op(MUL_OP_MUL, 32'd100, 32'd100, 5'd2, lat, bn, seen);
      e = pop_exp();
      total++; if (!seen || lat != exp_lat(MUL_OP_MUL, 32'd100)) $display("FAIL b2b_second_latency: got %0d (seen %0d) want %0d", lat, seen, exp_lat(MUL_OP_MUL, 32'd100)); else passed++;
      total++; if (bus.result !== e.res) $display("FAIL b2b_second_result: got %h want %h", bus.result, e.res); else passed++;
      total++; if (bus.rd_out !== e.rd) $display("FAIL b2b_second_rd: got %h want %h", bus.rd_out, e.rd); else passed++;
      last_res = e.res; last_rd = e.rd;
      @(negedge clk);
   endtask

   task automatic test_flush();
      bit extra;
      bus.op = MUL_OP_MUL; bus.src_a = 32'd5; bus.src_b = 32'h7FFFFFFF; bus.rd_in = 5'd7; bus.start_mul = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) bus.start_mul = 1'b0;
      end
      total++; if (bus.busy !== 1'b1) $display("FAIL flush_pre_busy: got %b want 1", bus.busy); else passed++;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL flush_idle_next: got busy %b want 0", bus.busy); else passed++;
      extra = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done_mul || bus.busy) extra = 1'b1; end
      total++; if (extra !== 1'b0) $display("FAIL flush_no_done: got activity %b want 0", extra); else passed++;
      total++; if (bus.result !== last_res) $display("FAIL flush_result_hold: got %h want %h", bus.result, last_res); else passed++;
      total++; if (bus.rd_out !== last_rd) $display("FAIL flush_rd_hold: got %h want %h", bus.rd_out, last_rd); else passed++;
      bus.src_a = 32'd3; bus.src_b = 32'd3; bus.rd_in = 5'd11; bus.start_mul = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      bus.start_mul = 1'b0; bus.flush = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL flush_start_dropped: got busy %b want 0", bus.busy); else passed++;
      extra = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done_mul) extra = 1'b1; end
      total++; if (extra !== 1'b0 || bus.result !== last_res) $display("FAIL flush_start_no_result: got done %b result %h want 0 %h", extra, bus.result, last_res); else passed++;
   endtask

   task automatic test_rst_mid();
      int lat, bn; bit seen, extra; exp_t e;
      bus.op = MUL_OP_MULHU; bus.src_a = 32'hDEADBEEF; bus.src_b = 32'hFFFF0001; bus.rd_in = 5'd13; bus.start_mul = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) bus.start_mul = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy); else passed++;
      total++; if (bus.done_mul !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", bus.done_mul); else passed++;
      total++; if (bus.result !== 32'h0) $display("FAIL rst_mid_result: got %h want 0", bus.result); else passed++;
      total++; if (bus.rd_out !== 5'h0) $display("FAIL rst_mid_rd: got %h want 0", bus.rd_out); else passed++;
      extra = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.done_mul) extra = 1'b1; end
      total++; if (extra !== 1'b0) $display("FAIL rst_mid_no_done: got %b want 0", extra); else passed++;
      push_exp(32'd144, 5'd5);
      run_op(MUL_OP_MUL, 32'd12, 32'd12, 5'd5, lat, bn, seen);
      e = pop_exp();
      total++; if (!seen || lat != exp_lat(MUL_OP_MUL, 32'd12)) $display("FAIL rst_mid_restart_latency: got %0d (seen %0d) want %0d", lat, seen, exp_lat(MUL_OP_MUL, 32'd12)); else passed++;
      total++; if (bus.result !== e.res || bus.rd_out !== e.rd) $display("FAIL rst_mid_restart_result: got %h/%h want %h/%h", bus.result, bus.rd_out, e.res, e.rd); else passed++;
      @(negedge clk);
   endtask

`ifdef MUL_EARLY_OUT_EN
   task automatic test_early_out();
      logic [31:0] bs [3] = '{32'h0, 32'h1, 32'h80};
      int want [3] = '{2, 2, 9};
      int lat, bn; bit seen; exp_t e;
      for (int i = 0; i < 3; i++) begin
         push_exp(ref_mul(MUL_OP_MUL, 32'h01234567, bs[i]), 5'd20);
         run_op(MUL_OP_MUL, 32'h01234567, bs[i], 5'd20, lat, bn, seen);
         e = pop_exp();
         total++; if (!seen || lat != want[i]) $display("FAIL early_out%0d_latency: got %0d (seen %0d) want %0d", i, lat, seen, want[i]); else passed++;
         total++; if (bus.result !== e.res) $display("FAIL early_out%0d_result: got %h want %h", i, bus.result, e.res); else passed++;
         @(negedge clk);
      end
   endtask
`endif

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'h00000001;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      int lat, bn; bit seen; exp_t e;
      logic [1:0] op; logic [31:0] a, b; logic [4:0] rd;
      for (int n = 0; n < 1000; n++) begin
         op = 2'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand(); rd = 5'($urandom_range(0, 31));
         push_exp(ref_mul(op, a, b), rd);
         run_op(op, a, b, rd, lat, bn, seen);
         e = pop_exp();
         total++;
         if (!seen || bus.result !== e.res || bus.rd_out !== e.rd || lat != exp_lat(op, b))
            $display("FAIL random%0d op=%0d a=%h b=%h: got %h/%h lat %0d want %h/%h lat %0d",
                     n, op, a, b, bus.result, bus.rd_out, lat, e.res, e.rd, exp_lat(op, b));
         else passed++;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_mul_basic();
      test_signed_cases();
      test_ignore_start();
      test_back_to_back();
      test_flush();
      test_rst_mid();
`ifdef MUL_EARLY_OUT_EN
      test_early_out();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
